// File: rtl/title_loader.sv
// Parses framed title-update packets from a byte stream into shadow registers and
// applies pending titles to the live outputs on the frame pulse.
module title_loader #(
    parameter int          NTITLE  = 3,
    parameter int          NCHAR   = 8,
    parameter logic [7:0]  SOF     = 8'h02,
    parameter int          TIMEOUT = 750000
) (
    input  logic                                clk_pix,
    input  logic                                rst_pix,
    input  logic                                rx_valid,
    input  logic [7:0]                          rx_data,
    input  logic                                frame,
    output logic [NTITLE-1:0][8*NCHAR-1:0]      titles,
    output logic                                upd_ok,
    output logic                                upd_err,
    output logic                                busy
);

    localparam int CW = $clog2(NCHAR + 1);
    localparam int GW = $clog2(TIMEOUT + 1);
    localparam logic [8*NCHAR-1:0] SPACES = {NCHAR{8'h20}};

    typedef enum logic [1:0] {IDLE, INDEX, CHARS, CHECK} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q;
    logic [GW-1:0]                   gap_q;
    logic [7:0]                      idx_q, chk_q;
    logic [NCHAR-1:0][7:0]           cbuf_q;
    logic [NTITLE-1:0][8*NCHAR-1:0]  shadow_q;
    logic [NTITLE-1:0]               pend_q;
    logic                            timeout, commit, reject;

    // Stored characters are folded to the displayable upper-case range.
    function automatic logic [7:0] sanitise(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h5F)      return c;
        else if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
        else                               return 8'h3F;
    endfunction

    assign busy    = (state_q != IDLE);
    assign timeout = busy && (gap_q == GW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        reject  = 1'b0;
        if (timeout) begin
            state_d = IDLE;
            reject  = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                IDLE:  if (rx_data == SOF) state_d = INDEX;
                INDEX: state_d = CHARS;
                CHARS: if (cnt_q == CW'(NCHAR - 1)) state_d = CHECK;
                CHECK: begin
                    state_d = IDLE;
                    if (rx_data == chk_q && idx_q < 8'(NTITLE)) commit = 1'b1;
                    else                                        reject = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            idx_q    <= '0;
            chk_q    <= '0;
            cbuf_q   <= SPACES;
            shadow_q <= {NTITLE{SPACES}};
            pend_q   <= '0;
            titles   <= {NTITLE{SPACES}};
            upd_ok   <= 1'b0;
            upd_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            upd_ok  <= commit;
            upd_err <= reject;

            // Saturating inter-byte gap counter, only meaningful inside a packet.
            if (state_d == IDLE || rx_valid) gap_q <= '0;
            else if (gap_q != GW'(TIMEOUT))  gap_q <= gap_q + 1'b1;

            if (rx_valid && !timeout) begin
                case (state_q)
                    INDEX: begin
                        idx_q <= rx_data;
                        chk_q <= rx_data;
                        cnt_q <= '0;
                    end
                    CHARS: begin
                        chk_q <= chk_q ^ rx_data;
                        cnt_q <= cnt_q + 1'b1;
                        for (int i = 0; i < NCHAR; i++)
                            if (cnt_q == CW'(i)) cbuf_q[i] <= sanitise(rx_data);
                    end
                    default: ;
                endcase
            end

            // Frame copies the pre-commit shadow; a same-cycle commit re-arms pend.
            for (int k = 0; k < NTITLE; k++) begin
                if (frame && pend_q[k]) begin
                    titles[k] <= shadow_q[k];
                    pend_q[k] <= 1'b0;
                end
                if (commit && idx_q == 8'(k)) begin
                    shadow_q[k] <= cbuf_q;
                    pend_q[k]   <= 1'b1;
                end
            end
        end
    end

endmodule
